// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Imported by the arbiter top and its winner-select sub-module.
package riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } arb_owner_t;

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Winner select between fetch and data requests.
// Data has priority until a pending fetch has lost P_STARVE_LIMIT times.
import riscv_mem_arb_pkg::*;

module riscv_mem_arb_pick #(
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inst_req,
    input  logic       i_data_req,
    input  logic       i_arb_en,
    output arb_owner_t o_owner
);

    localparam int LP_CW = $clog2(P_STARVE_LIMIT + 1);
    localparam logic [LP_CW-1:0] LP_LIMIT = LP_CW'(P_STARVE_LIMIT);

    logic [LP_CW-1:0] r_starve_cnt;
    logic             w_inst_win;

    always_comb begin
        w_inst_win = i_inst_req &&
                     (!i_data_req || (r_starve_cnt == LP_LIMIT));
        o_owner    = w_inst_win ? OWN_INST : OWN_DATA;
    end

    // Counter saturates at the limit because the fetch then wins outright.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en) begin
            if (w_inst_win) begin
                r_starve_cnt <= '0;
            end else if (i_inst_req && (r_starve_cnt != LP_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter: instruction fetch vs. load/store.
// One outstanding transaction, registered outputs, ready pulse per owner.
import riscv_mem_arb_pkg::*;

module riscv_mem_arbiter #(
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_ADDR_WIDTH   = 32,
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inst_rd_en,
    input  logic [P_ADDR_WIDTH-1:0] inst_addr,
    input  logic [3:0]              inst_ctrl_cpu,
    output logic [P_DATA_WIDTH-1:0] instr_data,
    output logic                    instr_ready,
    input  logic                    data_rd_en_ma,
    input  logic                    data_wr_en_ma,
    input  logic [P_ADDR_WIDTH-1:0] data_addr,
    input  logic [P_DATA_WIDTH-1:0] data_wr,
    input  logic [3:0]              data_rd_en_ctrl,
    output logic [P_DATA_WIDTH-1:0] data_rd,
    output logic                    data_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [P_ADDR_WIDTH-1:0] mem_addr,
    output logic [P_DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]              mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [P_DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    arb_owner_t w_owner;
    logic       w_data_req;
    logic       w_arb_en;

    assign w_data_req = data_rd_en_ma | data_wr_en_ma;
    assign w_arb_en   = (r_state == ARB_IDLE) && (inst_rd_en || w_data_req);

    riscv_mem_arb_pick #(
        .P_STARVE_LIMIT(P_STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .i_inst_req(inst_rd_en),
        .i_data_req(w_data_req),
        .i_arb_en  (w_arb_en),
        .o_owner   (w_owner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_INST;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            instr_data  <= '0;
            instr_ready <= 1'b0;
            data_rd     <= '0;
            data_ready  <= 1'b0;
        end else begin
            instr_ready <= 1'b0;
            data_ready  <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_arb_en) begin
                        r_owner <= w_owner;
                        mem_req <= 1'b1;
                        r_state <= ARB_REQ;
                        if (w_owner == OWN_INST) begin
                            mem_we   <= 1'b0;
                            mem_addr <= inst_addr;
                            mem_be   <= inst_ctrl_cpu;
                        end else begin
                            // A simultaneous read+write enable is a store.
                            mem_we    <= data_wr_en_ma;
                            mem_addr  <= data_addr;
                            mem_be    <= data_rd_en_ctrl;
                            mem_wdata <= data_wr;
                        end
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= ARB_RESP;
                        if (r_owner == OWN_INST) begin
                            instr_data  <= mem_rdata;
                            instr_ready <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                data_rd <= mem_rdata;
                            end
                            data_ready <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed scoreboard bench for riscv_mem_arbiter.
// Memory model answers requests; ready pulses are checked against a queue.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_rd_en;
    logic [31:0] inst_addr;
    logic [3:0]  inst_ctrl_cpu;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        data_rd_en_ma;
    logic        data_wr_en_ma;
    logic [31:0] data_addr;
    logic [31:0] data_wr;
    logic [3:0]  data_rd_en_ctrl;
    logic [31:0] data_rd;
    logic        data_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    riscv_mem_arbiter #(
        .P_DATA_WIDTH  (32),
        .P_ADDR_WIDTH  (32),
        .P_STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_rd_en     (inst_rd_en),
        .inst_addr      (inst_addr),
        .inst_ctrl_cpu  (inst_ctrl_cpu),
        .instr_data     (instr_data),
        .instr_ready    (instr_ready),
        .data_rd_en_ma  (data_rd_en_ma),
        .data_wr_en_ma  (data_wr_en_ma),
        .data_addr      (data_addr),
        .data_wr        (data_wr),
        .data_rd_en_ctrl(data_rd_en_ctrl),
        .data_rd        (data_rd),
        .data_ready     (data_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    typedef struct {
        bit          inst;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[logic [31:0]];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          gnt_delay = 0;
    int          gcnt = 0;
    bit          rsp_pend = 0;
    logic [31:0] rsp_data = '0;
    logic [31:0] last_rd = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit inst, input logic [31:0] d);
        exp_t e;
        e.inst = inst;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input bit inst, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inst ? instr_ready : data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        data_addr       = a;
        data_rd_en_ctrl = 4'hF;
        data_rd_en_ma   = 1'b1;
        push(1'b0, exp);
        last_rd = exp;
        wait_ready(1'b0, "load_done");
        @(posedge clk); #1;
        data_rd_en_ma = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"},
            32'({mem_req, mem_we, instr_ready, data_ready, mem_be}), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdat"}, mem_wdata, 32'd0);
        chk({tag, "_idat"}, instr_data, 32'd0);
        chk({tag, "_drd"}, data_rd, 32'd0);
    endtask

    // Memory model: grants after gnt_delay idle request cycles, responds next cycle.
    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!reset) begin
            rsp_pend = 1'b0;
            gcnt     = 0;
        end else if (rsp_pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_data;
            rsp_pend   = 1'b0;
        end else if (mem_req) begin
            if (gcnt == gnt_delay) begin
                mem_gnt  = 1'b1;
                gcnt     = 0;
                rsp_pend = 1'b1;
                if (mem_we) begin
                    logic [31:0] cur;
                    cur = mem_rd(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem[mem_addr] = cur;
                    n_writes++;
                    rsp_data = $urandom;
                end else begin
                    rsp_data = mem_rd(mem_addr);
                end
            end else begin
                gcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset && (instr_ready || data_ready)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'({instr_ready, data_ready}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_owner", 32'({instr_ready, data_ready}),
                    e.inst ? 32'd2 : 32'd1);
                chk("ready_data", e.inst ? instr_data : data_rd, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        int wr_before;
        bit done;
        reset = 1'b0;
        inst_rd_en = 1'b0;
        inst_addr = '0;
        inst_ctrl_cpu = '0;
        data_rd_en_ma = 1'b0;
        data_wr_en_ma = 1'b0;
        data_addr = '0;
        data_wr = '0;
        data_rd_en_ctrl = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        mem[32'h100] = 32'h0050_0093;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset_starve", 32'(dut.u_pick.r_starve_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // single fetch, cycle-exact latency
        @(posedge clk); #1;
        inst_addr = 32'h100;
        inst_ctrl_cpu = 4'hF;
        inst_rd_en = 1'b1;
        push(1'b1, 32'h0050_0093);
        @(negedge clk);
        chk("t1_c0_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("t1_c1_req", 32'(mem_req), 32'd1);
        chk("t1_c1_addr", mem_addr, 32'h100);
        chk("t1_c1_be", 32'(mem_be), 32'hF);
        chk("t1_c1_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("t1_c2_req", 32'(mem_req), 32'd0);
        chk("t1_c2_rdy", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("t1_c3_rdy", 32'(instr_ready), 32'd1);
        chk("t1_c3_data", instr_data, 32'h0050_0093);
        chk("t1_c3_drdy", 32'(data_ready), 32'd0);
        @(posedge clk); #1;
        inst_rd_en = 1'b0;
        @(negedge clk);
        chk("t1_c4_rdy", 32'(instr_ready), 32'd0);
        repeat (2) @(posedge clk);

        // simultaneous fetch and load: load first
        #1;
        inst_addr = 32'h104;
        inst_rd_en = 1'b1;
        data_addr = 32'h2000;
        data_rd_en_ctrl = 4'hC;
        data_rd_en_ma = 1'b1;
        push(1'b0, 32'h2000 ^ 32'h5A5A_5A5A);
        push(1'b1, 32'h0104 ^ 32'h5A5A_5A5A);
        last_rd = 32'h2000 ^ 32'h5A5A_5A5A;
        @(negedge clk);
        @(negedge clk);
        chk("t2_req", 32'(mem_req), 32'd1);
        chk("t2_addr", mem_addr, 32'h2000);
        chk("t2_be", 32'(mem_be), 32'hC);
        wait_ready(1'b0, "t2_load_done");
        @(posedge clk); #1;
        data_rd_en_ma = 1'b0;
        wait_ready(1'b1, "t2_fetch_done");
        @(posedge clk); #1;
        inst_rd_en = 1'b0;

        // store with delayed grant
        gnt_delay = 2;
        @(posedge clk); #1;
        data_addr = 32'h2004;
        data_wr = 32'hDEAD_BEEF;
        data_rd_en_ctrl = 4'b0011;
        data_wr_en_ma = 1'b1;
        push(1'b0, last_rd);
        req_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                chk("t3_addr", mem_addr, 32'h2004);
                chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
                chk("t3_be", 32'(mem_be), 32'h3);
                chk("t3_we", 32'(mem_we), 32'd1);
            end
            if (data_ready) done = 1'b1;
        end
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_req_cycles", 32'(req_cycles), 32'd3);
        chk("t3_data_rd", data_rd, 32'h2000 ^ 32'h5A5A_5A5A);
        @(posedge clk); #1;
        data_wr_en_ma = 1'b0;
        gnt_delay = 0;

        // starvation: fetch wins the 5th arbitration
        @(posedge clk); #1;
        inst_addr = 32'h300;
        inst_rd_en = 1'b1;
        data_addr = 32'h3000;
        data_rd_en_ctrl = 4'hF;
        data_rd_en_ma = 1'b1;
        for (int k = 0; k < 4; k++)
            push(1'b0, (32'h3000 + 32'(4 * k)) ^ 32'h5A5A_5A5A);
        push(1'b1, 32'h300 ^ 32'h5A5A_5A5A);
        push(1'b0, 32'h3010 ^ 32'h5A5A_5A5A);
        for (int k = 0; k < 4; k++) begin
            wait_ready(1'b0, "t4_load_done");
            @(posedge clk); #1;
            data_addr = data_addr + 32'd4;
        end
        chk("t4_starve_max", 32'(dut.u_pick.r_starve_cnt), 32'd4);
        wait_ready(1'b1, "t4_fetch_done");
        chk("t4_starve_clr", 32'(dut.u_pick.r_starve_cnt), 32'd0);
        @(posedge clk); #1;
        inst_rd_en = 1'b0;
        wait_ready(1'b0, "t4_last_load");
        @(posedge clk); #1;
        data_rd_en_ma = 1'b0;
        last_rd = 32'h3010 ^ 32'h5A5A_5A5A;

        // read and write enables together: one store
        @(posedge clk); #1;
        wr_before = n_writes;
        data_addr = 32'h2008;
        data_wr = 32'h1234_5678;
        data_rd_en_ctrl = 4'hF;
        data_rd_en_ma = 1'b1;
        data_wr_en_ma = 1'b1;
        push(1'b0, last_rd);
        @(negedge clk);
        @(negedge clk);
        chk("t5_req", 32'(mem_req), 32'd1);
        chk("t5_we", 32'(mem_we), 32'd1);
        wait_ready(1'b0, "t5_done");
        @(posedge clk); #1;
        data_rd_en_ma = 1'b0;
        data_wr_en_ma = 1'b0;
        chk("t5_one_write", 32'(n_writes - wr_before), 32'd1);
        do_load(32'h2008, 32'h1234_5678);
        do_load(32'h2004, 32'h5A5A_BEEF);

        // reset while waiting for the response
        @(posedge clk); #1;
        inst_addr = 32'h400;
        inst_rd_en = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        inst_rd_en = 1'b0;
        #1;
        chk_zero("t6_rst");
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        inst_addr = 32'h100;
        inst_rd_en = 1'b1;
        push(1'b1, 32'h0050_0093);
        wait_ready(1'b1, "t6_fetch_done");
        @(posedge clk); #1;
        inst_rd_en = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
